time_keeper: RTL and testbench



---
 rtl/clock_pkg.sv | 15 +
 rtl/time_keeper_if.sv | 27 ++
 rtl/btn_edge.sv | 36 +++
 rtl/time_keeper.sv | 86 ++++++++
 tb/tb_time_keeper.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared widths and limits for the time-of-day counter, plus a wrap-around
// increment helper used by both the tick cascade and the set buttons.
package clock_pkg;
  localparam int TIME_W = 6;

  typedef logic [TIME_W-1:0] time_t;

  localparam time_t SEC_MAX  = 6'd59;
  localparam time_t MIN_MAX  = 6'd59;
  localparam time_t HOUR_MAX = 6'd23;

  function automatic time_t wrap_inc(input time_t v, input time_t max_v);
    return (v == max_v) ? '0 : v + 1'b1;
  endfunction
endpackage

// File: rtl/time_keeper_if.sv
// Control/button inputs and time/strobe outputs of time_keeper. PRESC_W must
// equal $clog2(CLK_HZ) of the attached time_keeper.
interface time_keeper_if #(parameter int PRESC_W = 27);
  import clock_pkg::*;

  logic               run;
  logic               set_mode;
  logic               inc_hour;
  logic               inc_min;
  logic               clr_sec;
  time_t              hour;
  time_t              min;
  time_t              sec;
  logic               tick_1hz;
  logic               hour_strobe;
  logic [PRESC_W-1:0] presc_dbg;

  modport master (
    output run, set_mode, inc_hour, inc_min, clr_sec,
    input  hour, min, sec, tick_1hz, hour_strobe, presc_dbg
  );

  modport slave (
    input  run, set_mode, inc_hour, inc_min, clr_sec,
    output hour, min, sec, tick_1hz, hour_strobe, presc_dbg
  );
endinterface

// File: rtl/btn_edge.sv
// Two-flop synchronizer for a raw button, followed by a registered rising-edge
// pulse: one clk-wide pulse per press, however long the button is held.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
endmodule

// File: rtl/time_keeper.sv
// 24-hour time-of-day counter: CLK_HZ prescaler to a 1 Hz tick, cascaded
// sec/min/hour counters, and button-driven adjustment in set mode.
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input logic         clk,
  input logic         rst,
  time_keeper_if.slave tk
);
  localparam int                 PRESC_W    = $clog2(CLK_HZ);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  time_t              sec_q, sec_d;
  time_t              min_q, min_d;
  time_t              hour_q, hour_d;
  logic               counting;
  logic               tick;
  logic               strobe;
  logic               inc_hour_p, inc_min_p, clr_sec_p;

  btn_edge u_inc_hour (.clk(clk), .rst(rst), .btn(tk.inc_hour), .pulse(inc_hour_p));
  btn_edge u_inc_min  (.clk(clk), .rst(rst), .btn(tk.inc_min),  .pulse(inc_min_p));
  btn_edge u_clr_sec  (.clk(clk), .rst(rst), .btn(tk.clr_sec),  .pulse(clr_sec_p));

  always_comb begin
    counting = tk.run & ~tk.set_mode;
    tick     = counting & (presc_q == PRESC_LAST);

    // Prescaler holds its value while not counting so a paused second resumes.
    presc_d = presc_q;
    if (clr_sec_p || tick) begin
      presc_d = '0;
    end else if (counting) begin
      presc_d = presc_q + 1'b1;
    end

    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    strobe = 1'b0;

    // A clear wins over a coincident tick: the tick still pulses, nothing carries.
    if (clr_sec_p) begin
      sec_d = '0;
    end else if (tick) begin
      sec_d = wrap_inc(sec_q, SEC_MAX);
      if (sec_q == SEC_MAX) begin
        min_d = wrap_inc(min_q, MIN_MAX);
        if (min_q == MIN_MAX) begin
          hour_d = wrap_inc(hour_q, HOUR_MAX);
          strobe = 1'b1;
        end
      end
    end

    // Adjustment never carries; a tick cannot coincide since counting is off.
    if (tk.set_mode) begin
      if (inc_hour_p) hour_d = wrap_inc(hour_q, HOUR_MAX);
      if (inc_min_p)  min_d  = wrap_inc(min_q, MIN_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
    end
  end

  assign tk.hour        = hour_q;
  assign tk.min         = min_q;
  assign tk.sec         = sec_q;
  assign tk.tick_1hz    = tick;
  assign tk.hour_strobe = strobe;
  assign tk.presc_dbg   = presc_q;
endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper at CLK_HZ=4: tick placement, a table of timed runs
// scored through an expected queue, and hand-written button/clear/reset cases.
module tb_time_keeper;
  localparam int CLK_HZ  = 4;
  localparam int PRESC_W = $clog2(CLK_HZ);

  logic clk;
  logic rst;

  time_keeper_if #(.PRESC_W(PRESC_W)) tk ();

  time_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk (clk),
    .rst (rst),
    .tk  (tk)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  logic [23:0] exp_q[$];

  typedef struct {
    int h, m, s, n;
    int eh, em, es, estr;
  } row_t;

  row_t rows[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, "_hour"}, 32'(tk.hour), h);
    chk({name, "_min"},  32'(tk.min),  m);
    chk({name, "_sec"},  32'(tk.sec),  s);
  endtask

  // driver tasks
  task automatic idle_inputs();
    tk.run      = 1'b0;
    tk.set_mode = 1'b0;
    tk.inc_hour = 1'b0;
    tk.inc_min  = 1'b0;
    tk.clr_sec  = 1'b0;
  endtask

  task automatic press(input logic hour_b, input logic min_b, input logic clr_b);
    tk.inc_hour = hour_b;
    tk.inc_min  = min_b;
    tk.clr_sec  = clr_b;
    repeat (4) @(negedge clk);
    tk.inc_hour = 1'b0;
    tk.inc_min  = 1'b0;
    tk.clr_sec  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Reset, dial hour/min with the buttons, then count up to s seconds.
  task automatic set_time(input int h, input int m, input int s);
    int nmax;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tk.set_mode = 1'b1;
    nmax = (h > m) ? h : m;
    for (int i = 0; i < nmax; i++) press(i < h, i < m, 1'b0);
    tk.set_mode = 1'b0;
    tk.run = 1'b1;
    repeat (s * CLK_HZ) @(negedge clk);
    tk.run = 1'b0;
  endtask

  initial begin
    logic [23:0] exp_v;
    int strobes;
    n_cmp = 0;
    n_bad = 0;

    rows[0] = '{h: 0,  m: 0,  s: 0,  n: 4, eh: 0,  em: 0,  es: 4,  estr: 0};
    rows[1] = '{h: 0,  m: 0,  s: 58, n: 3, eh: 0,  em: 1,  es: 1,  estr: 0};
    rows[2] = '{h: 5,  m: 59, s: 58, n: 4, eh: 6,  em: 0,  es: 2,  estr: 1};
    rows[3] = '{h: 23, m: 59, s: 58, n: 2, eh: 0,  em: 0,  es: 0,  estr: 1};
    rows[4] = '{h: 12, m: 34, s: 0,  n: 1, eh: 12, em: 34, es: 1,  estr: 0};

    // reset state
    rst = 1'b1;
    idle_inputs();
    #1;
    chk_time("reset", 0, 0, 0);
    chk("reset_tick",   32'(tk.tick_1hz),    0);
    chk("reset_strobe", 32'(tk.hour_strobe), 0);
    chk("reset_presc",  32'(tk.presc_dbg),   0);

    // tick lands in cycles 4, 8, 12, 16 of continuous counting
    @(negedge clk);
    rst = 1'b0;
    tk.run = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("tick_cycle%0d", k), 32'(tk.tick_1hz), (k % CLK_HZ == 0) ? 1 : 0);
      @(negedge clk);
    end
    tk.run = 1'b0;
    chk_time("run16", 0, 0, 4);

    // table rows: expected result queued at drive, compared after the window
    for (int r = 0; r < 5; r++) begin
      set_time(rows[r].h, rows[r].m, rows[r].s);
      exp_q.push_back({6'(rows[r].eh), 6'(rows[r].em), 6'(rows[r].es), 6'(rows[r].estr)});
      strobes = 0;
      tk.run = 1'b1;
      for (int k = 0; k < rows[r].n * CLK_HZ; k++) begin
        if (tk.hour_strobe) begin
          strobes++;
          chk($sformatf("row%0d_strobe_with_tick", r), 32'(tk.tick_1hz), 1);
        end
        @(negedge clk);
      end
      tk.run = 1'b0;
      exp_v = exp_q.pop_front();
      chk($sformatf("row%0d_hms_strobes", r),
          {8'd0, tk.hour, tk.min, tk.sec, 6'(strobes)}, {8'd0, exp_v});
    end

    // held inc_min from 59: one pulse only, no carry; then inc_hour 23 -> 0
    set_time(23, 59, 0);
    tk.set_mode = 1'b1;
    tk.inc_min = 1'b1;
    repeat (20) @(negedge clk);
    tk.inc_min = 1'b0;
    repeat (4) @(negedge clk);
    chk_time("hold_min", 23, 0, 0);
    press(1'b1, 1'b0, 1'b0);
    chk_time("hour_wrap", 0, 0, 0);

    // inc pulses outside set mode are dropped, not queued
    tk.set_mode = 1'b0;
    press(1'b0, 1'b1, 1'b0);
    tk.set_mode = 1'b1;
    repeat (4) @(negedge clk);
    chk_time("inc_outside_set", 0, 0, 0);

    // both buttons together at 05:10, latency N+3
    set_time(5, 10, 0);
    tk.set_mode = 1'b1;
    tk.inc_hour = 1'b1;
    tk.inc_min  = 1'b1;
    repeat (3) @(negedge clk);
    chk_time("dual_n2", 5, 10, 0);
    @(negedge clk);
    chk_time("dual_n3", 6, 11, 0);
    tk.inc_hour = 1'b0;
    tk.inc_min  = 1'b0;
    repeat (4) @(negedge clk);

    // clr_sec pulse lands on the tick that would wrap 01:02:59
    set_time(1, 2, 59);
    tk.run = 1'b1;
    tk.clr_sec = 1'b1;
    repeat (3) @(negedge clk);
    chk("clr_tick_still_pulses", 32'(tk.tick_1hz), 1);
    @(negedge clk);
    chk_time("clr_over_tick", 1, 2, 0);
    chk("clr_over_tick_presc", 32'(tk.presc_dbg), 0);
    tk.clr_sec = 1'b0;
    repeat (4) @(negedge clk);
    chk_time("after_clr", 1, 2, 1);

    // set_mode freezes the prescaler; clr_sec still clears it there
    repeat (2) @(negedge clk);
    tk.set_mode = 1'b1;
    repeat (5) @(negedge clk);
    chk("freeze_presc", 32'(tk.presc_dbg), 2);
    tk.clr_sec = 1'b1;
    repeat (4) @(negedge clk);
    chk("clr_in_set_presc", 32'(tk.presc_dbg), 0);
    chk_time("clr_in_set", 1, 2, 0);
    tk.clr_sec = 1'b0;
    tk.set_mode = 1'b0;
    repeat (4) @(negedge clk);
    chk_time("resume_after_clr", 1, 2, 1);

    // asynchronous reset between edges at 12:34:56
    set_time(12, 34, 56);
    tk.run = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst_presc", 32'(tk.presc_dbg), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * CLK_HZ) @(negedge clk);
    chk_time("after_rst", 0, 0, 2);
    tk.run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
